// File: rtl/uart_tx_tick_if.sv
// Producer-side handshake for the tick-driven UART transmitter.
// The producer is master; the transmitter is slave.
interface uart_tx_tick_if #(
  parameter int DBITS = 8
);
  logic             tx_start;
  logic [DBITS-1:0] din;
  logic             busy;
  logic             tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output busy,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by a 16x oversample enable (s_tick).
// Frame: start bit, DBITS data bits LSB first, SB_TICK/16 stop bits.
module uart_tx_tick #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_tick,
  output logic           tx,
  uart_tx_tick_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(15);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);

  state_t           state, state_n;
  logic [SW-1:0]    s_cnt, s_cnt_n;
  logic [NW-1:0]    n_cnt, n_cnt_n;
  logic [DBITS-1:0] b_reg, b_reg_n;
  logic [DBITS-1:0] b_shift;
  logic             tx_reg, tx_reg_n;
  logic             done;

  assign b_shift = b_reg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      b_reg  <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_n;
      s_cnt  <= s_cnt_n;
      n_cnt  <= n_cnt_n;
      b_reg  <= b_reg_n;
      tx_reg <= tx_reg_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_cnt_n  = s_cnt;
    n_cnt_n  = n_cnt;
    b_reg_n  = b_reg;
    tx_reg_n = tx_reg;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tx_start) begin
          b_reg_n  = bus.din;
          s_cnt_n  = '0;
          state_n  = START;
          tx_reg_n = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_n  = '0;
            n_cnt_n  = '0;
            state_n  = DATA;
            tx_reg_n = b_reg[0];
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_n = '0;
            b_reg_n = b_shift;
            if (n_cnt == N_LAST) begin
              state_n  = STOP;
              tx_reg_n = 1'b1;
            end else begin
              n_cnt_n  = n_cnt + 1'b1;
              tx_reg_n = b_shift[0];
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SB_LAST) begin
            s_cnt_n = '0;
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign tx               = tx_reg;
  assign bus.busy         = (state != IDLE);
  assign bus.tx_done_tick = done;

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial transmitter that sits directly downstream of the reloadable down-counter timer.
- Consumes the timer's one-cycle `tick` as a 16x-oversampled baud enable (`s_tick`) and serialises a parallel word onto a UART line: start bit, DBITS data bits LSB first, then stop bit(s).
- Provides a simple start/busy/done handshake to the upstream producer.

Parameters:
- DBITS, 8, number of data bits per frame (1..16).
- SB_TICK, 16, number of s_tick periods in the stop interval: 16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_tick  input  1  oversample enable, 16 per bit period; typically the timer's tick.
- tx_start  input  1  request to send din; sampled only in IDLE.
- din  input  DBITS  data word to transmit.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever a frame is in progress.
- tx_done_tick  output  1  one-cycle pulse at the end of the stop interval.

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst=1 at a rising edge forces: state=IDLE, s_cnt=0, n_cnt=0, shift reg=0, tx=1.
  - With state=IDLE, busy=0 and tx_done_tick=0.
  - Reset overrides all other inputs.
- Internal registers:
  - state: IDLE, START, DATA, STOP.
  - s_cnt: wide enough for max(16, SB_TICK).
  - n_cnt: index of the current data bit.
  - b_reg: DBITS-wide shift register.
  - tx_reg: drives tx directly; tx is registered, no combinational path from inputs.
- IDLE:
  - tx=1.
  - If tx_start=1: b_reg<=din, s_cnt<=0, state<=START, tx<=0, all on the same edge.
  - tx falls in the cycle after tx_start is sampled.
- START:
  - tx=0.
  - On s_tick: if s_cnt==15, then s_cnt<=0, n_cnt<=0, state<=DATA, tx<=b_reg[0]; else s_cnt<=s_cnt+1.
- DATA:
  - tx=b_reg[0].
  - On s_tick with s_cnt==15: s_cnt<=0, b_reg<=b_reg>>1.
    - If n_cnt==DBITS-1: state<=STOP, tx<=1.
    - Otherwise: n_cnt<=n_cnt+1, tx<=next bit.
  - On s_tick with s_cnt!=15: s_cnt<=s_cnt+1.
- STOP:
  - tx=1.
  - On s_tick with s_cnt==SB_TICK-1: state<=IDLE, tx_done_tick=1 in that cycle (Mealy, combinational from state/s_tick/s_cnt).
  - Otherwise on s_tick: s_cnt<=s_cnt+1.
- Cycles with s_tick=0 hold all registers in every state; the frame stretches with tick spacing.
- busy is combinational from state: busy = (state != IDLE).
- tx_start while busy=1 is ignored and not queued, including in the tx_done_tick cycle. A request is accepted at the earliest in the first IDLE cycle.
- din is only sampled on the accepting edge; later changes to din do not affect the frame.
- Frame length in s_ticks: 16 + 16*DBITS + SB_TICK.
- Back-to-back frames: tx_start held high produces frames separated by exactly one IDLE cycle (tx=1).
- Reset mid-frame:
  - The line returns to 1 in the cycle after the reset edge.
  - No tx_done_tick is produced.
  - The partial frame is abandoned.

Test Plan:
1. s_tick=1 every cycle, DBITS=8, SB_TICK=16, din=0xA5, tx_start pulsed in cycle 0 -> busy=1 from cycle 1; tx=0 in cycles 1-16; data bits 1,0,1,0,0,1,0,1 in 16-cycle slots over cycles 17-144; tx=1 in cycles 145-160; tx_done_tick=1 only in cycle 160; busy=0 from cycle 161.
2. s_tick from the timer with d_in=3 (one tick every 4 clocks), din=0x00 -> every bit period is 64 clocks; tx low for 9*64 clocks after the start edge; done pulse after 10*64 clocks of frame.
3. tx_start pulsed in cycle 50 of frame 1 with din=0xFF, and again in the tx_done_tick cycle -> both ignored; frame 1 bits unchanged; tx stays 1 and busy=0 afterwards.
4. tx_start held high, din=0x3C then 0xC3 after acceptance -> two frames; the second carries the value present on the re-accept edge; exactly one IDLE cycle between them.
5. rst asserted in cycle 80 of a frame (DATA state) -> tx=1, busy=0 from cycle 81; no tx_done_tick; a new tx_start in cycle 85 transmits a clean full frame.
6. SB_TICK=32, s_tick every cycle, din=0x01 -> stop interval is 32 cycles; tx_done_tick arrives 16 cycles later than in scenario 1.
